// File: rtl/id_stage.sv
// MIPS decode/operand-fetch stage: 32x32 register file, Ed32 formation, one-entry EX output register.
// Optional load-use interlock enabled by defining ID_HAZARD_EN.
module id_stage #(
   parameter int unsigned NREG     = 32,
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] Ins_in,
   input  logic [31:0] nextPC_in,
   input  logic        Flush,
   input  logic        WE,
   input  logic [4:0]  Waddr,
   input  logic [31:0] Wdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Ins,
   output logic [31:0] Rdata1,
   output logic [31:0] Rdata2,
   output logic [31:0] Ed32,
   output logic [31:0] nextPC,
   output logic        hazard_stall
);

   logic [31:0] r_rf [NREG];
   logic        r_valid;
   logic [31:0] r_ins;
   logic [31:0] r_rdata1;
   logic [31:0] r_rdata2;
   logic [31:0] r_ed32;
   logic [31:0] r_npc;

   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic        w_wr_en;
   logic [31:0] w_rd1;
   logic [31:0] w_rd2;
   logic [31:0] w_ed32;
   logic        w_hazard;
   logic        w_capture;
   logic        w_hold_hit1;
   logic        w_hold_hit2;

   assign w_rs    = Ins_in[25:21];
   assign w_rt    = Ins_in[20:16];
   assign w_op    = Ins_in[31:26];
   assign w_funct = Ins_in[5:0];
   assign w_wr_en = WE && (Waddr != 5'd0);

   // Read ports with write-through so a same-cycle writeback is never missed.
   always_comb begin
      w_rd1 = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
      w_rd2 = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
      if (w_wr_en && (Waddr == w_rs)) w_rd1 = Wdata;
      if (w_wr_en && (Waddr == w_rt)) w_rd2 = Wdata;
   end

   always_comb begin
      w_ed32 = {{16{Ins_in[15]}}, Ins_in[15:0]};
      case (w_op)
         6'h00: begin
            if (w_funct == 6'h00 || w_funct == 6'h02 || w_funct == 6'h03) begin
               w_ed32 = {27'd0, Ins_in[10:6]};
            end else begin
               w_ed32 = 32'd0;
            end
         end
         6'h0C, 6'h0D, 6'h0E: w_ed32 = {16'd0, Ins_in[15:0]};
         6'h0F:               w_ed32 = {Ins_in[15:0], 16'd0};
         6'h02, 6'h03:        w_ed32 = {nextPC_in[31:28], Ins_in[25:0], 2'b00};
         default:             ;
      endcase
   end

`ifdef ID_HAZARD_EN
   // Load in EX slot whose destination feeds the incoming instruction.
   assign w_hazard = r_valid && (r_ins[31:26] == 6'h23) && (r_ins[20:16] != 5'd0) && in_valid
                     && ((r_ins[20:16] == w_rs) || (r_ins[20:16] == w_rt));
`else
   assign w_hazard = 1'b0;
`endif

   assign in_ready    = (!r_valid || out_ready) && !w_hazard;
   assign w_capture   = in_valid && in_ready && !Flush;
   assign w_hold_hit1 = w_wr_en && (Waddr == r_ins[25:21]);
   assign w_hold_hit2 = w_wr_en && (Waddr == r_ins[20:16]);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rf     <= '{default: 32'd0};
         r_valid  <= 1'b0;
         r_ins    <= 32'd0;
         r_rdata1 <= 32'd0;
         r_rdata2 <= 32'd0;
         r_ed32   <= 32'd0;
         r_npc    <= RESET_PC;
      end else begin
         if (w_wr_en) r_rf[Waddr] <= Wdata;
         if (Flush) begin
            r_valid <= 1'b0;
         end else if (w_capture) begin
            r_valid  <= 1'b1;
            r_ins    <= Ins_in;
            r_npc    <= nextPC_in;
            r_rdata1 <= w_rd1;
            r_rdata2 <= w_rd2;
            r_ed32   <= w_ed32;
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end else if (r_valid) begin
            // Held operands track writebacks so EX sees current register values.
            if (w_hold_hit1) r_rdata1 <= Wdata;
            if (w_hold_hit2) r_rdata2 <= Wdata;
         end
      end
   end

   assign out_valid    = r_valid;
   assign Ins          = r_ins;
   assign Rdata1       = r_rdata1;
   assign Rdata2       = r_rdata2;
   assign Ed32         = r_ed32;
   assign nextPC       = r_npc;
   assign hazard_stall = w_hazard;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; hazard expectations follow ID_HAZARD_EN.
module tb_id_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] Ins_in;
   logic [31:0] nextPC_in;
   logic        Flush;
   logic        WE;
   logic [4:0]  Waddr;
   logic [31:0] Wdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Ins;
   logic [31:0] Rdata1;
   logic [31:0] Rdata2;
   logic [31:0] Ed32;
   logic [31:0] nextPC;
   logic        hazard_stall;

   int n_checks = 0;
   int n_pass   = 0;

   id_stage dut (
      .CLK          (CLK),
      .RST          (RST),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .Ins_in       (Ins_in),
      .nextPC_in    (nextPC_in),
      .Flush        (Flush),
      .WE           (WE),
      .Waddr        (Waddr),
      .Wdata        (Wdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .Ins          (Ins),
      .Rdata1       (Rdata1),
      .Rdata2       (Rdata2),
      .Ed32         (Ed32),
      .nextPC       (nextPC),
      .hazard_stall (hazard_stall)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] npc);
      in_valid  = 1'b1;
      Ins_in    = ins;
      nextPC_in = npc;
      step();
      in_valid  = 1'b0;
   endtask

   initial begin
      RST = 1'b1; in_valid = 1'b0; Ins_in = '0; nextPC_in = '0; Flush = 1'b0;
      WE = 1'b0; Waddr = '0; Wdata = '0; out_ready = 1'b1;
      step(); step();
      RST = 1'b0;
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_ins", Ins, 32'd0);
      check("rst_rd1", Rdata1, 32'd0);
      check("rst_rd2", Rdata2, 32'd0);
      check("rst_ed32", Ed32, 32'd0);
      check("rst_npc", nextPC, 32'd0);
      check("rst_hz", {31'd0, hazard_stall}, 32'd0);
      check("rst_inrdy", {31'd0, in_ready}, 32'd1);

      // Load R5=5, R3=3
      WE = 1'b1; Waddr = 5'd5; Wdata = 32'd5; step();
      Waddr = 5'd3; Wdata = 32'd3; step();
      WE = 1'b0;

      issue(32'h00A31820, 32'h00000100);
      check("add_valid", {31'd0, out_valid}, 32'd1);
      check("add_ins", Ins, 32'h00A31820);
      check("add_rd1", Rdata1, 32'd5);
      check("add_rd2", Rdata2, 32'd3);
      check("add_ed32", Ed32, 32'd0);
      check("add_npc", nextPC, 32'h00000100);

      issue(32'h00031080, 32'h00000104);
      check("sll_ed32", Ed32, 32'h00000002);
      check("sll_rd2", Rdata2, 32'd3);
      issue(32'h3400FFFF, 32'h00000108);
      check("ori_ed32", Ed32, 32'h0000FFFF);
      issue(32'h2000FFFF, 32'h0000010C);
      check("addi_ed32", Ed32, 32'hFFFFFFFF);
      issue(32'h3C001234, 32'h00000110);
      check("lui_ed32", Ed32, 32'h12340000);
      issue(32'h08000400, 32'h00000004);
      check("j_ed32", Ed32, 32'h00001000);
      check("j_npc", nextPC, 32'h00000004);
      issue(32'h0C000001, 32'hA0000004);
      check("jal_ed32", Ed32, 32'hA0000004);

      // Writes to R0 are dropped, including on the bypass path
      WE = 1'b1; Waddr = 5'd0; Wdata = 32'hDEADBEEF;
      issue(32'h00001020, 32'h00000200);
      check("r0_rd1", Rdata1, 32'd0);
      check("r0_rd2", Rdata2, 32'd0);

      // Same-cycle writeback bypass into capture
      Waddr = 5'd5; Wdata = 32'h00001234;
      issue(32'h00A31820, 32'h00000300);
      WE = 1'b0;
      check("byp_rd1", Rdata1, 32'h00001234);
      check("byp_rd2", Rdata2, 32'd3);

      // Stall: held operand follows writeback, everything else frozen
      out_ready = 1'b0;
      in_valid = 1'b1; Ins_in = 32'h3400FFFF; nextPC_in = 32'h00000400;
      #1;
      check("stall_inrdy", {31'd0, in_ready}, 32'd0);
      WE = 1'b1; Waddr = 5'd5; Wdata = 32'h00000055;
      step();
      WE = 1'b0; in_valid = 1'b0;
      check("stall_rd1", Rdata1, 32'h00000055);
      check("stall_rd2", Rdata2, 32'd3);
      check("stall_ins", Ins, 32'h00A31820);
      check("stall_ed32", Ed32, 32'd0);
      check("stall_npc", nextPC, 32'h00000300);
      check("stall_valid", {31'd0, out_valid}, 32'd1);

      // Pop without new input
      out_ready = 1'b1;
      step();
      check("pop_valid", {31'd0, out_valid}, 32'd0);
      check("pop_ins", Ins, 32'h00A31820);

      // Flush with valid bundle and valid input; RF write still lands
      issue(32'h00031080, 32'h00000500);
      check("pre_fl_valid", {31'd0, out_valid}, 32'd1);
      Flush = 1'b1; WE = 1'b1; Waddr = 5'd7; Wdata = 32'h00000077;
      issue(32'h3400AAAA, 32'h00000504);
      Flush = 1'b0; WE = 1'b0;
      check("fl_valid", {31'd0, out_valid}, 32'd0);
      issue(32'h00E00020, 32'h00000600);
      check("fl_rf_r7", Rdata1, 32'h00000077);
      check("fl_ins", Ins, 32'h00E00020);

      // Load-use: LW rt=8 then ADD rs=8
      issue(32'h8C080000, 32'h00000700);
      check("lw_ins", Ins, 32'h8C080000);
      in_valid = 1'b1; Ins_in = 32'h01000020; nextPC_in = 32'h00000704;
      #1;
`ifdef ID_HAZARD_EN
      check("hz_on", {31'd0, hazard_stall}, 32'd1);
      check("hz_inrdy", {31'd0, in_ready}, 32'd0);
      step();
      check("hz_bubble", {31'd0, out_valid}, 32'd0);
      check("hz_clear", {31'd0, hazard_stall}, 32'd0);
      step();
`else
      check("hz_off", {31'd0, hazard_stall}, 32'd0);
      check("hz_inrdy", {31'd0, in_ready}, 32'd1);
      step();
`endif
      in_valid = 1'b0;
      check("hz_add_valid", {31'd0, out_valid}, 32'd1);
      check("hz_add_ins", Ins, 32'h01000020);

      // Reset mid-transfer discards bundle and clears RF
      out_ready = 1'b0;
      RST = 1'b1; step(); RST = 1'b0;
      check("rst2_valid", {31'd0, out_valid}, 32'd0);
      check("rst2_rd1", Rdata1, 32'd0);
      check("rst2_npc", nextPC, 32'd0);
      out_ready = 1'b1;
      issue(32'h00A31820, 32'h00000800);
      check("rst2_rf_r5", Rdata1, 32'd0);
      check("rst2_rf_r3", Rdata2, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- MIPS decode/operand-fetch stage; the producer side of the EX-stage operand interface (Ins, Rdata1, Rdata2, Ed32, nextPC).
- Holds the 32x32 register file and forms Ed32 per opcode.
- Registers one decoded instruction toward EX behind a valid/ready handshake.
- Accepts the writeback port from WB.

Parameters:
- NREG, 32, number of architectural registers (addressed by 5 bits; only 32 is supported).
- RESET_PC, 32'h00000000, value driven on nextPC while out_valid=0 after reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  ID accepts this cycle.
- Ins_in  in  32  fetched instruction.
- nextPC_in  in  32  PC+4 of the fetched instruction.
- Flush  in  1  discard the held and incoming instruction (taken branch/jump).
- WE  in  1  writeback enable.
- Waddr  in  5  writeback register number.
- Wdata  in  32  writeback data.
- out_valid  out  1  EX bundle valid.
- out_ready  in  1  EX consumes the bundle this cycle.
- Ins  out  32  registered instruction.
- Rdata1  out  32  R[rs].
- Rdata2  out  32  R[rt].
- Ed32  out  32  extended immediate/shamt/jump target.
- nextPC  out  32  registered PC+4.
- hazard_stall  out  1  load-use interlock active (0 when the optional feature is absent).

Behaviour:
- Reset (RST=1 at edge): all 32 registers cleared to 0. out_valid=0, Ins=0, Rdata1=0, Rdata2=0, Ed32=0, nextPC=RESET_PC, hazard_stall=0. Reset mid-transfer discards the bundle.
- R[0] reads as 0 always. Writes with Waddr=0 are ignored.
- RF write: on edge when WE=1 and Waddr!=0.
- in_ready = (!out_valid || out_ready) && !hazard_stall. It is combinational.
- Capture: when in_valid && in_ready && !Flush, at the edge the stage loads Ins, nextPC, Rdata1, Rdata2 and Ed32, and sets out_valid=1. Latency is 1 cycle from acceptance to out_valid.
- Pop without new input: out_valid && out_ready && !(in_valid && in_ready) gives out_valid=0 next cycle. Output data is held.
- Stall: while out_valid && !out_ready, all outputs stay stable. Exception: if WE && Waddr!=0 && Waddr matches the held rs (or rt), the held Rdata1 (or Rdata2) is replaced with Wdata.
- Flush: has priority over everything except RST. Next cycle out_valid=0 and the incoming instruction is dropped. RF writes still occur in a flush cycle.
- Write-through bypass on capture: if WE && Waddr!=0 && Waddr==rs, Rdata1 captures Wdata, not the stale RF value; same rule for rt and Rdata2.
- Ed32 formation, by op=Ins_in[31:26] and funct=Ins_in[5:0]:
  - op=0, funct in {0,2,3} (SLL/SRL/SRA): {27'b0, Ins_in[10:6]}.
  - op=0, other funct: 0.
  - op in {0x0C,0x0D,0x0E} (ANDI/ORI/XORI): zero-extended imm16.
  - op=0x0F (LUI): {imm16, 16'h0}.
  - op in {0x02,0x03} (J/JAL): {nextPC_in[31:28], Ins_in[25:0], 2'b00}.
  - All other opcodes: sign-extended imm16.
- Simultaneous pop+capture in the same cycle: new bundle replaces old, out_valid stays 1.

Optional Feature:
- Macro: ID_HAZARD_EN.
- Defined: hazard_stall=1 when out_valid && Ins[31:26]==0x23 (LW) && Ins[20:16]!=0 && in_valid && Ins[20:16] equals Ins_in[25:21] or Ins_in[20:16]. This forces in_ready=0. If out_ready=1 in that cycle, a bubble is inserted (out_valid=0 next cycle) and the instruction is accepted the following cycle.
- Undefined: hazard_stall tied 0; no interlock logic synthesized.

Test Plan:
- Reset then write R5=5, R3=3; issue 0x00A31820 (ADD rs=5, rt=3) -> next cycle out_valid=1, Rdata1=5, Rdata2=3, Ed32=0.
- Issue 0x00031080 (SLL shamt=2) -> Ed32=0x00000002. Issue 0x3400FFFF (ORI) -> Ed32=0x0000FFFF. Issue 0x2000FFFF (ADDI) -> Ed32=0xFFFFFFFF.
- Issue 0x08000400 with nextPC_in=0x00000004 -> Ed32=0x00001000, nextPC=0x00000004.
- Same-cycle writeback R5=0x1234 while capturing an instruction with rs=5 -> Rdata1=0x1234. Hold out_ready=0 and write R5=0x55 -> held Rdata1 becomes 0x55, all other outputs unchanged.
- Flush asserted with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, instruction dropped, a concurrent RF write is still committed.
- With ID_HAZARD_EN: LW rt=8 in output stage, incoming ADD rs=8 -> hazard_stall=1, one bubble, ADD issued the cycle after. Without the macro -> no stall.
